// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, releases core.
// Define PLL_LOCK_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_lock_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries,
  output logic [7:0] loss_cnt
);

  localparam int M1 =
    (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int M2 =
    (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
  localparam int CW = $clog2(M2 + 1);

  localparam logic [CW-1:0] RC = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SC = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TC = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    MR = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    rsync;
  logic [1:0]    lsync;
  logic          rst_ok;
  logic          locked_s;
  logic [3:0]    ret_inc;

  assign rst_ok   = rsync[1];
  assign locked_s = lsync[1];
  assign ret_inc  = retries + 4'd1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rsync <= '0;
      lsync <= '0;
    end else begin
      rsync <= {rsync[0], 1'b1};
      lsync <= {lsync[0], locked};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      pll_rst    <= 1'b1;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else if (restart) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      pll_rst    <= 1'b1;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else if (!rst_ok) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      case (state)
        S_PLL_RST: begin
          if (cnt == RC) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TC) begin
            cnt     <= '0;
            retries <= ret_inc;
            pll_rst <= 1'b1;
            if (ret_inc == MR) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state <= S_PLL_RST;
            end
          end
        end
        // a drop on the completing cycle still wins over RUN
        S_STABLE: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == SC) begin
            state      <= S_RUN;
            cnt        <= '0;
            retries    <= '0;
            core_rst_n <= 1'b1;
            ready      <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= '0;
          if (!locked_s) begin
            state      <= S_PLL_RST;
            pll_rst    <= 1'b1;
            core_rst_n <= 1'b0;
            ready      <= 1'b0;
          end
        end
        S_FAIL: begin
          cnt <= '0;
        end
        default: begin
          state      <= S_PLL_RST;
          cnt        <= '0;
          pll_rst    <= 1'b1;
          core_rst_n <= 1'b0;
          ready      <= 1'b0;
          fail       <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = (state == S_RUN) && !locked_s
                    && !restart && rst_ok;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_evt && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pll_lock_seq;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 16;
  localparam int MR = 3;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retries;
  logic [7:0] loss_cnt;

  always #5 refclk = ~refclk;

  pll_lock_seq #(
    .RST_CYCLES  (RC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .MAX_RETRY   (MR)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retries   (retries),
    .loss_cnt  (loss_cnt)
  );

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  function automatic int act(input int sel);
    case (sel)
      0: return int'(pll_rst);
      1: return int'(core_rst_n);
      2: return int'(ready);
      3: return int'(fail);
      4: return int'(retries);
      default: return int'(loss_cnt);
    endcase
  endfunction

  function automatic int lossx(input int n);
    if (!LOSS_EN) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  always @(negedge refclk) begin : mon
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (act(e.sel) != e.val) begin
        bad++;
        $display("FAIL %s: got %0d want %0d",
                 e.name, act(e.sel), e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input int sel,
                     input int val);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic outs(input string nm, input int p,
                      input int c, input int r, input int f);
    chk({nm, "_pll_rst"}, 0, p);
    chk({nm, "_core_rst_n"}, 1, c);
    chk({nm, "_ready"}, 2, r);
    chk({nm, "_fail"}, 3, f);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic bring_up();
    rst_n = 1'b1;
    tick(6);
    chk("up_prst_fall", 0, 0);
    locked = 1'b1;
    tick(11);
    outs("up_run", 0, 1, 1, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    tick(2);
    outs("reset", 1, 0, 0, 0);
    chk("reset_retries", 4, 0);
    chk("reset_loss", 5, 0);

    // lock arrives right after the PLL reset pulse
    rst_n = 1'b1;
    tick(5);
    chk("prst_hold", 0, 1);
    tick(1);
    chk("prst_fall", 0, 0);
    locked = 1'b1;
    tick(10);
    chk("lat_pre_core", 1, 0);
    chk("lat_pre_ready", 2, 0);
    tick(1);
    outs("lat_run", 0, 1, 1, 0);
    chk("lat_retries", 4, 0);

    // lock loss in RUN
    locked = 1'b0;
    tick(2);
    chk("loss_pre_core", 1, 1);
    tick(1);
    outs("loss", 1, 0, 0, 0);
    chk("loss_cnt1", 5, lossx(1));
    tick(3);
    chk("loss_prst_hold", 0, 1);
    tick(1);
    chk("loss_prst_fall", 0, 0);
    locked = 1'b1;
    tick(10);
    chk("relock_pre", 1, 0);
    tick(1);
    chk("relock_run", 1, 1);

    // restart, then a 1-cycle glitch at STABLE count 5
    pulse_restart();
    outs("restart", 1, 0, 0, 0);
    chk("restart_loss", 5, lossx(1));
    tick(8);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("glitch_core", 1, 0);
    tick(8);
    chk("recount_pre", 1, 0);
    chk("recount_retries", 4, 0);
    tick(1);
    chk("recount_run", 1, 1);

    // drop lands on the cycle the STABLE count completes
    pulse_restart();
    tick(10);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("edge_drop_core", 1, 0);
    chk("edge_drop_ready", 2, 0);
    tick(8);
    chk("edge_recount_pre", 1, 0);
    tick(1);
    chk("edge_recount_run", 1, 1);

    // no lock: three timeouts into FAIL
    locked = 1'b0;
    pulse_restart();
    tick(19);
    chk("to1_pre_ret", 4, 0);
    chk("to1_pre_prst", 0, 0);
    tick(1);
    chk("to1_ret", 4, 1);
    chk("to1_prst", 0, 1);
    tick(19);
    chk("to2_pre_ret", 4, 1);
    tick(1);
    chk("to2_ret", 4, 2);
    tick(19);
    chk("to3_pre_ret", 4, 2);
    chk("to3_pre_fail", 3, 0);
    tick(1);
    chk("to3_ret", 4, 3);
    outs("fail", 1, 0, 0, 1);
    tick(20);
    chk("fail_hold", 3, 1);
    chk("fail_hold_prst", 0, 1);
    chk("fail_hold_ret", 4, 3);
    pulse_restart();
    outs("fail_restart", 1, 0, 0, 0);
    chk("fail_restart_ret", 4, 0);

    // one timeout, then lock: RUN entry clears retries
    tick(20);
    chk("clr_ret1", 4, 1);
    tick(4);
    chk("clr_prst_fall", 0, 0);
    locked = 1'b1;
    tick(10);
    chk("clr_pre_ret", 4, 1);
    tick(1);
    chk("clr_run_ret", 4, 0);
    chk("clr_run_ready", 2, 1);

    // asynchronous reset in the middle of STABLE
    pulse_restart();
    tick(7);
    chk("stable_prst", 0, 0);
    tick(1);
    rst_n = 1'b0;
    locked = 1'b0;
    #1;
    outs("async_rst", 1, 0, 0, 0);
    chk("async_rst_ret", 4, 0);
    chk("async_rst_loss", 5, 0);
    tick(2);
    bring_up();

    // repeated losses drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(13);
      chk("sat_ready", 2, 1);
      chk("sat_loss", 5, lossx(i + 1));
    end

    @(negedge refclk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: pll_rst pulse length in refclk cycles (>=1).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-lock cycles required before core release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry (>=2).
REQ-004 SHALL have parameter MAX_RETRY, default 4: timeouts tolerated before FAIL (1..15).
REQ-005 SHALL have port refclk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port locked  in  1  PLL lock, asynchronous to refclk.
REQ-008 SHALL have port restart  in  1  one-cycle pulse forcing a full resequence.
REQ-009 SHALL have port pll_rst  out  1  active-high reset to the PLL.
REQ-010 SHALL have port core_rst_n  out  1  active-low reset to downstream logic.
REQ-011 SHALL have port ready  out  1  high only in RUN.
REQ-012 SHALL have port fail  out  1  high only in FAIL.
REQ-013 SHALL have port retries  out  4  timeouts since the last RUN entry or restart.
REQ-014 SHALL have port loss_cnt  out  8  saturating count of lock losses in RUN.

Function
REQ-015 SHALL pass locked through a 2-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL with one shared cycle counter, cleared on every state change.
REQ-017 PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with locked_s=0 -> retries+1, then FAIL if new value equals MAX_RETRY, else PLL_RST.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK (timeout restarts, retries unchanged); LOCK_STABLE consecutive locked_s=1 cycles -> RUN.
REQ-020 RUN: core_rst_n=1, ready=1, retries cleared on entry; locked_s=0 -> core_rst_n and ready fall on the next edge, loss_cnt+1 (saturating at 255), state PLL_RST.
REQ-021 FAIL: pll_rst=1, core_rst_n=0, fail=1; exited only by restart or rst_n.
REQ-022 core_rst_n, pll_rst, ready, fail SHALL be registered outputs, glitch-free; core_rst_n=0 in every state except RUN.
REQ-023 restart=1 in any state SHALL take priority over all other transitions: next state PLL_RST, counter and retries cleared, loss_cnt kept.
REQ-024 Latency: locked rising edge to core_rst_n rising SHALL be 2 (sync) + LOCK_STABLE + 1 cycles.
REQ-025 Lock dropping on the same cycle the STABLE count completes SHALL go to WAIT_LOCK, not RUN.

Reset
REQ-026 rst_n low SHALL asynchronously force: state PLL_RST, counter 0, synchronizer 0, pll_rst=1, core_rst_n=0, ready=0, fail=0, retries=0, loss_cnt=0.
REQ-027 Deassertion of rst_n SHALL be internally synchronized to refclk (2-flop) before the state machine leaves PLL_RST.

Configuration
REQ-028 Macro PLL_LOCK_SEQ_LOSS_CNT_EN defined: loss_cnt counter built per REQ-020; undefined: no counter registers, loss_cnt tied to 0, port list unchanged.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=16, MAX_RETRY=3)
REQ-029 locked held 1 after reset -> pll_rst high 4 cycles, core_rst_n rises 2+8+1=11 cycles after first locked-visible edge, ready=1.
REQ-030 locked held 0 -> three 16-cycle WAIT_LOCK windows, retries 1,2,3, fail=1, pll_rst=1 held; restart pulse -> retries=0, new PLL_RST.
REQ-031 locked drops for 1 cycle at STABLE count 5 -> back to WAIT_LOCK, core_rst_n stays 0, full 8-cycle recount after relock.
REQ-032 locked drops in RUN -> core_rst_n=0 and ready=0 within 3 cycles, loss_cnt=1, pll_rst pulse of 4; with macro undefined loss_cnt=0.
REQ-033 rst_n asserted mid-STABLE -> all outputs at reset values immediately, no refclk edge required.
REQ-034 300 forced losses in RUN -> loss_cnt saturates at 255.
